// File: rtl/dsdac_mod.sv
// Delta-sigma modulator for the DCO integer bank: first-order or MASH 1-1
// error feedback on the fractional field of the loop-filter word, with optional LFSR dither.
module dsdac_mod #(
    parameter int IN_W   = 16,
    parameter int INT_W  = 6,
    parameter int FRAC_W = IN_W - INT_W,
    parameter int LFSR_W = 15
) (
    input  logic              clk_mod,
    input  logic              n_rst,
    input  logic              enable,
    input  logic [IN_W-1:0]   code_in,
    input  logic              code_valid,
    input  logic              order_sel,
    input  logic              dither_en,
    output logic [INT_W-1:0]  dco_code,
    output logic              sat
);

    localparam logic [LFSR_W-1:0]       LFSR_SEED = LFSR_W'(1);
    localparam logic signed [INT_W+1:0] T_MAX     = $signed({2'b00, {INT_W{1'b1}}});

    logic [IN_W-1:0]         code_reg;
    logic [FRAC_W-1:0]       acc1;
    logic [FRAC_W-1:0]       acc2;
    logic                    c2_d;
    logic [LFSR_W-1:0]       lfsr;

    logic [INT_W-1:0]        int_part;
    logic [FRAC_W-1:0]       frac;
    logic                    dith;
    logic [FRAC_W:0]         s1;
    logic [FRAC_W:0]         s2;
    logic                    c1;
    logic                    c2;
    logic signed [2:0]       y;
    logic signed [INT_W+1:0] t;
    logic [INT_W-1:0]        dco_nxt;
    logic                    sat_nxt;
    logic [LFSR_W-1:0]       lfsr_nxt;

    assign int_part = code_reg[IN_W-1:FRAC_W];
    assign frac     = code_reg[FRAC_W-1:0];
    assign dith     = dither_en & lfsr[0];

    // Accumulators wrap modulo 2^FRAC_W; the dropped MSB is the carry out.
    assign s1 = {1'b0, acc1} + {1'b0, frac} + {{FRAC_W{1'b0}}, dith};
    assign s2 = {1'b0, acc2} + {1'b0, s1[FRAC_W-1:0]};
    assign c1 = s1[FRAC_W];
    assign c2 = s2[FRAC_W];

    assign lfsr_nxt = {lfsr[LFSR_W-2:0], lfsr[LFSR_W-1] ^ lfsr[LFSR_W-2]};

    always_comb begin
        y = $signed({2'b00, c1});
        if (order_sel) begin
            y = $signed({2'b00, c1}) + $signed({2'b00, c2}) - $signed({2'b00, c2_d});
        end
    end

    assign t = $signed({2'b00, int_part}) + $signed({{(INT_W-1){y[2]}}, y});

    always_comb begin
        dco_nxt = t[INT_W-1:0];
        sat_nxt = 1'b0;
        if (t[INT_W+1]) begin
            dco_nxt = '0;
            sat_nxt = 1'b1;
        end else if (t > T_MAX) begin
            dco_nxt = '1;
            sat_nxt = 1'b1;
        end
    end

    // Code capture is independent of enable so the loop filter can preload while paused.
    always_ff @(posedge clk_mod or negedge n_rst) begin
        if (!n_rst) begin
            code_reg <= '0;
        end else if (code_valid) begin
            code_reg <= code_in;
        end
    end

    always_ff @(posedge clk_mod or negedge n_rst) begin
        if (!n_rst) begin
            acc1     <= '0;
            acc2     <= '0;
            c2_d     <= 1'b0;
            lfsr     <= LFSR_SEED;
            dco_code <= '0;
            sat      <= 1'b0;
        end else if (enable) begin
            acc1     <= s1[FRAC_W-1:0];
            lfsr     <= lfsr_nxt;
            dco_code <= dco_nxt;
            sat      <= sat_nxt;
            if (order_sel) begin
                acc2 <= s2[FRAC_W-1:0];
                c2_d <= c2;
            end else begin
                // Keep stage 2 clean so a later switch to MASH starts from zero.
                acc2 <= '0;
                c2_d <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dsdac_mod.sv
// Self-checking bench for dsdac_mod: integer-arithmetic reference model compared
// every cycle, plus directed literal expectations for averaging, clamping, pause and reset.
module tb_dsdac_mod;

    logic        clk_mod    = 1'b0;
    logic        n_rst      = 1'b0;
    logic        enable     = 1'b0;
    logic [15:0] code_in    = '0;
    logic        code_valid = 1'b0;
    logic        order_sel  = 1'b0;
    logic        dither_en  = 1'b0;
    logic [5:0]  dco_code;
    logic        sat;

    int vectors     = 0;
    int miscompares = 0;

    int m_code = 0;
    int m_acc1 = 0;
    int m_acc2 = 0;
    int m_c2d  = 0;
    int m_lfsr = 1;
    int m_dco  = 0;
    int m_sat  = 0;

    int refseq[40];

    localparam logic [15:0] CODE_X = 16'h2155;
    localparam logic [15:0] CODE_Y = 16'h3A77;

    dsdac_mod dut (
        .clk_mod    (clk_mod),
        .n_rst      (n_rst),
        .enable     (enable),
        .code_in    (code_in),
        .code_valid (code_valid),
        .order_sel  (order_sel),
        .dither_en  (dither_en),
        .dco_code   (dco_code),
        .sat        (sat)
    );

    always #5 clk_mod = ~clk_mod;

    function automatic void check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: fraction accumulation in plain integers modulo 1024.
    always @(posedge clk_mod or negedge n_rst) begin : model
        int ip, fr, d, s1, c1, a1, s2, c2, y, tt, nl;
        if (!n_rst) begin
            m_code <= 0;
            m_acc1 <= 0;
            m_acc2 <= 0;
            m_c2d  <= 0;
            m_lfsr <= 1;
            m_dco  <= 0;
            m_sat  <= 0;
        end else begin
            if (enable) begin
                ip = m_code / 1024;
                fr = m_code % 1024;
                d  = dither_en ? (m_lfsr % 2) : 0;
                s1 = m_acc1 + fr + d;
                c1 = s1 / 1024;
                a1 = s1 % 1024;
                m_acc1 <= a1;
                if (order_sel) begin
                    s2 = m_acc2 + a1;
                    c2 = s2 / 1024;
                    y  = c1 + c2 - m_c2d;
                    m_acc2 <= s2 % 1024;
                    m_c2d  <= c2;
                end else begin
                    y = c1;
                    m_acc2 <= 0;
                    m_c2d  <= 0;
                end
                nl = ((m_lfsr * 2) % 32768) + (((m_lfsr / 16384) + (m_lfsr / 8192)) % 2);
                m_lfsr <= nl;
                tt = ip + y;
                if (tt < 0) begin
                    m_dco <= 0;
                    m_sat <= 1;
                end else if (tt > 63) begin
                    m_dco <= 63;
                    m_sat <= 1;
                end else begin
                    m_dco <= tt;
                    m_sat <= 0;
                end
            end
            if (code_valid) m_code <= int'(code_in);
        end
    end

    always @(negedge clk_mod) begin
        check("model_dco", int'(dco_code), m_dco);
        check("model_sat", int'(sat), m_sat);
    end

    task automatic cyc(input logic en, input logic cv, input logic [15:0] c);
        enable     = en;
        code_valid = cv;
        code_in    = c;
        @(negedge clk_mod);
    endtask

    // Asserts reset a few ns after a rising edge, checks the outputs clear at once,
    // and releases on the following falling edge.
    task automatic do_reset();
        @(posedge clk_mod);
        #3 n_rst = 1'b0;
        #1;
        check("async_rst_dco", int'(dco_code), 0);
        check("async_rst_sat", int'(sat), 0);
        @(negedge clk_mod);
        n_rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sum;
        int cnt;
        int held;

        @(negedge clk_mod);
        check("rst_dco", int'(dco_code), 0);
        check("rst_sat", int'(sat), 0);
        n_rst = 1'b1;

        // Midscale, first order
        cyc(1'b1, 1'b1, 16'h8000);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0, 16'h0000);
            check("mid_dco", int'(dco_code), 32);
            check("mid_sat", int'(sat), 0);
        end

        // Half fraction, first order: 2,3,2,3...
        cyc(1'b1, 1'b1, 16'h0A00);
        sum = 0;
        for (int i = 0; i < 1024; i++) begin
            cyc(1'b1, 1'b0, 16'h0000);
            if (i == 0) check("half_first", int'(dco_code), 2);
            if (i == 1) check("half_second", int'(dco_code), 3);
            sum += int'(dco_code);
        end
        check("half_sum", sum, 2560);

        // MASH 1-1 from a clean state, frac = 1
        do_reset();
        order_sel = 1'b1;
        cyc(1'b0, 1'b1, 16'h1401);
        sum = 0;
        cnt = 0;
        for (int i = 0; i < 1024; i++) begin
            cyc(1'b1, 1'b0, 16'h0000);
            sum += int'(dco_code);
            if (dco_code < 6'd4 || dco_code > 6'd7) cnt++;
        end
        check("mash_sum", sum, 5121);
        check("mash_out_of_range", cnt, 0);

        // Clamping at both ends
        cyc(1'b1, 1'b1, 16'hFFFF);
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            cyc(1'b1, 1'b0, 16'h0000);
            if (sat && dco_code == 6'd63) cnt++;
        end
        check("clamp_hi_seen", int'(cnt > 0), 1);
        cyc(1'b1, 1'b1, 16'h0001);
        cnt = 0;
        for (int i = 0; i < 1024; i++) begin
            cyc(1'b1, 1'b0, 16'h0000);
            if (sat && dco_code == 6'd0) cnt++;
        end
        check("clamp_lo_seen", int'(cnt > 0), 1);

        // Uninterrupted reference sequence, MASH with dither
        dither_en = 1'b1;
        do_reset();
        cyc(1'b0, 1'b1, CODE_X);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b0, 16'h0000);
            refseq[i] = m_dco;
        end
        cyc(1'b0, 1'b1, CODE_Y);
        for (int i = 20; i < 40; i++) begin
            cyc(1'b1, 1'b0, 16'h0000);
            refseq[i] = m_dco;
        end

        // Same run with a 17-cycle pause; CODE_Y is loaded while paused
        do_reset();
        cyc(1'b0, 1'b1, CODE_X);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b0, 16'h0000);
            check("pause_pre", int'(dco_code), refseq[i]);
        end
        held = int'(dco_code);
        for (int j = 0; j < 17; j++) begin
            cyc(1'b0, (j == 8), (j == 8) ? CODE_Y : 16'h0000);
            check("pause_frozen", int'(dco_code), held);
        end
        for (int i = 20; i < 40; i++) begin
            cyc(1'b1, 1'b0, 16'h0000);
            check("pause_post", int'(dco_code), refseq[i]);
        end

        // Asynchronous reset mid-run, then a fresh run must match the reference
        for (int i = 0; i < 13; i++) cyc(1'b1, 1'b0, 16'h0000);
        do_reset();
        cyc(1'b0, 1'b1, CODE_X);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b0, 16'h0000);
            check("rerun_pre", int'(dco_code), refseq[i]);
        end
        cyc(1'b0, 1'b1, CODE_Y);
        for (int i = 20; i < 40; i++) begin
            cyc(1'b1, 1'b0, 16'h0000);
            check("rerun_post", int'(dco_code), refseq[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
